// File: rtl/avmm_cmd_engine.sv
// avmm_cmd_engine: table-driven Avalon-MM master (write, masked poll, delay, end).
// Define AVMM_CMD_ENGINE_READLOG_EN to add the LAST_READDATA debug capture port.
module avmm_cmd_engine #(
   parameter int P_ADDRSIZE  = 8,
   parameter int P_DATASIZE  = 32,
   parameter int P_DEPTH     = 16,
   parameter int P_POLL_MAX  = 1024,
   parameter int P_DELAYSIZE = 16
) (
   input  logic                                CLOCK,
   input  logic                                RESET_N,
   input  logic                                START,
   output logic                                BUSY,
   output logic                                DONE,
   output logic                                ERROR,
   output logic [$clog2(P_DEPTH)-1:0]          ERR_INDEX,
   output logic [$clog2(P_DEPTH)-1:0]          CMD_INDEX,
   input  logic [2+P_ADDRSIZE+2*P_DATASIZE-1:0] CMD_WORD,
   output logic                                AVM_M0_READ,
   output logic                                AVM_M0_WRITE,
   input  logic                                AVM_M0_WAITREQUEST,
   output logic [P_ADDRSIZE-1:0]               AVM_M0_ADDRESS,
   input  logic [P_DATASIZE-1:0]               AVM_M0_READDATA,
   output logic [P_DATASIZE-1:0]               AVM_M0_WRITEDATA
`ifdef AVMM_CMD_ENGINE_READLOG_EN
   ,
   output logic [P_DATASIZE-1:0]               LAST_READDATA
`endif
);

   localparam int CW  = $clog2(P_DEPTH);
   localparam int CWW = 2 + P_ADDRSIZE + 2 * P_DATASIZE;
   localparam int PW  = CWW - 2;
   localparam int DW  = P_DELAYSIZE;
   localparam int PCW = (P_POLL_MAX < 2) ? 1 : $clog2(P_POLL_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WRITE, S_READ,
      S_GAP, S_DELAY, S_DONE, S_ERROR
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   err_q, err_d;
   logic [PW-1:0]   cmd_q, cmd_d;
   logic [PCW-1:0]  poll_q, poll_d;
   logic [DW-1:0]   dly_q, dly_d;
   logic            adv;

   logic [1:0]            w_op;
   logic [DW-1:0]         w_dly;
   logic [P_ADDRSIZE-1:0] c_addr;
   logic [P_DATASIZE-1:0] c_mask;
   logic [P_DATASIZE-1:0] c_data;
   logic                  match;

   assign w_op   = CMD_WORD[CWW-1 -: 2];
   assign w_dly  = CMD_WORD[DW-1:0];
   assign c_addr = cmd_q[2*P_DATASIZE +: P_ADDRSIZE];
   assign c_mask = cmd_q[P_DATASIZE +: P_DATASIZE];
   assign c_data = cmd_q[0 +: P_DATASIZE];
   assign match  = (AVM_M0_READDATA & c_mask) == (c_data & c_mask);

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         err_q   <= '0;
         cmd_q   <= '0;
         poll_q  <= '0;
         dly_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         cmd_q   <= cmd_d;
         poll_q  <= poll_d;
         dly_q   <= dly_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = err_q;
      cmd_d   = cmd_q;
      poll_d  = poll_q;
      dly_d   = dly_q;
      adv     = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (START) begin
               idx_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            cmd_d  = CMD_WORD[PW-1:0];
            poll_d = '0;
            unique case (w_op)
               2'b00: state_d = S_WRITE;
               2'b01: state_d = S_READ;
               2'b10: begin
                  if (w_dly == '0) begin
                     adv = 1'b1;
                  end else begin
                     dly_d   = w_dly;
                     state_d = S_DELAY;
                  end
               end
               2'b11: state_d = S_DONE;
               default: state_d = S_DONE;
            endcase
         end
         S_WRITE: begin
            if (!AVM_M0_WAITREQUEST) adv = 1'b1;
         end
         S_READ: begin
            if (!AVM_M0_WAITREQUEST) begin
               if (match) begin
                  adv = 1'b1;
               end else begin
                  poll_d = poll_q + PCW'(1);
                  // P_POLL_MAX of 0 means the poll never gives up
                  if (P_POLL_MAX != 0 &&
                      poll_d == PCW'(P_POLL_MAX)) begin
                     err_d   = idx_q;
                     state_d = S_ERROR;
                  end else begin
                     state_d = S_GAP;
                  end
               end
            end
         end
         S_GAP: state_d = S_READ;
         S_DELAY: begin
            if (dly_q == DW'(1)) adv = 1'b1;
            else dly_d = dly_q - DW'(1);
         end
         default: state_d = S_IDLE;
      endcase
      if (adv) begin
         if (idx_q == CW'(P_DEPTH - 1)) begin
            state_d = S_DONE;
         end else begin
            idx_d   = idx_q + CW'(1);
            state_d = S_FETCH;
         end
      end
   end

   assign BUSY  = state_q inside {S_FETCH, S_WRITE, S_READ,
                                  S_GAP, S_DELAY};
   assign DONE  = state_q == S_DONE;
   assign ERROR = state_q == S_ERROR;
   assign ERR_INDEX = err_q;
   assign CMD_INDEX = idx_q;

   assign AVM_M0_WRITE     = state_q == S_WRITE;
   assign AVM_M0_READ      = state_q == S_READ;
   assign AVM_M0_ADDRESS   = (AVM_M0_WRITE || AVM_M0_READ) ?
                             c_addr : '0;
   assign AVM_M0_WRITEDATA = AVM_M0_WRITE ? c_data : '0;

`ifdef AVMM_CMD_ENGINE_READLOG_EN
   logic [P_DATASIZE-1:0] rlog_q;

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         rlog_q <= '0;
      end else if (state_q == S_READ && !AVM_M0_WAITREQUEST) begin
         rlog_q <= AVM_M0_READDATA;
      end
   end

   assign LAST_READDATA = rlog_q;
`endif

endmodule
